// File: rtl/fp_seq_pkg.sv
`default_nettype none
// ============================================================================
// fp_seq_pkg : shared types and defaults for the fp op sequencer
// Rev 1.0
// ============================================================================
package fp_seq_pkg;

    localparam int c_DATA_W      = 16;
    localparam int c_TIMEOUT_CYC = 32;
    localparam int c_CNT_W       = 8;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        WAIT_A = 3'd0,
        WAIT_B = 3'd1,
        ISSUE  = 3'd2,
        EXEC   = 3'd3,
        RESP   = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// fp_op_sequencer_if : operand, op-unit and result signals of the sequencer
// Rev 1.0
// ============================================================================
interface fp_op_sequencer_if
    import fp_seq_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int CNT_W  = c_CNT_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_start;
    logic              op_done;
    logic [DATA_W-1:0] op_result;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              timeout_err;
    logic [CNT_W-1:0]  op_count;

    // Sequencer side
    modport slave (
        input  in_data, in_valid, op_done, op_result, out_ready,
        output in_ready, op_a, op_b, op_start, out_data, out_valid,
               busy, timeout_err, op_count
    );

    // Environment side: operand source, op unit and result consumer
    modport master (
        output in_data, in_valid, op_done, op_result, out_ready,
        input  in_ready, op_a, op_b, op_start, out_data, out_valid,
               busy, timeout_err, op_count
    );
endinterface
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ============================================================================
// seq_timer : EXEC-phase watchdog counter with clear/enable
// Rev 1.0
// ============================================================================
module seq_timer
    import fp_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int             c_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [c_W-1:0] c_LAST = c_W'(TIMEOUT_CYC - 1);

    logic [c_W-1:0] r_count;
    logic [c_W-1:0] w_count_inc;

    assign w_count_inc = r_count + c_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_count_inc;
        end
    end

    // Fires on the cycle whose increment reaches the limit, so the op is
    // abandoned TIMEOUT_CYC cycles after the start pulse.
    assign expired = enable && (w_count_inc == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fp_op_sequencer.sv
`default_nettype none
// ============================================================================
// fp_op_sequencer : collects two operands, runs one fp op, returns the result
// Rev 1.0
// ============================================================================
module fp_op_sequencer
    import fp_seq_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC,
    parameter int CNT_W       = c_CNT_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fp_op_sequencer_if.slave   bus
);
    seq_state_t r_state;
    seq_state_t w_next_state;

    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_op_count;
    logic              r_timeout_err;

    logic w_in_ready;
    logic w_op_start;
    logic w_out_valid;
    logic w_busy;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_expired;
    logic w_accept;

    assign w_accept = bus.in_valid && w_in_ready;

    seq_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_A:  if (w_accept) w_next_state = WAIT_B;
            WAIT_B:  if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = EXEC;
            EXEC:    if (bus.op_done || w_expired) w_next_state = RESP;
            RESP:    if (bus.out_ready) w_next_state = WAIT_A;
            default: w_next_state = WAIT_A;
        endcase
    end

    always_comb begin
        w_in_ready    = 1'b0;
        w_op_start    = 1'b0;
        w_out_valid   = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        w_busy        = (r_state != WAIT_A);
        case (r_state)
            WAIT_A, WAIT_B: w_in_ready = 1'b1;
            ISSUE: begin
                w_op_start    = 1'b1;
                w_timer_clear = 1'b1;
            end
            EXEC:    w_timer_en  = 1'b1;
            RESP:    w_out_valid = 1'b1;
            default: w_in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_out_data    <= '0;
            r_op_count    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == WAIT_A && w_accept) r_op_a <= bus.in_data;
            if (r_state == WAIT_B && w_accept) r_op_b <= bus.in_data;
            // A real completion takes priority over a simultaneous timeout.
            if (r_state == EXEC) begin
                if (bus.op_done) begin
                    r_out_data <= bus.op_result;
                end else if (w_expired) begin
                    r_out_data    <= DATA_W'(FP16_QNAN);
                    r_timeout_err <= 1'b1;
                end
            end
            if (r_state == RESP && bus.out_ready) r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.op_a        = r_op_a;
    assign bus.op_b        = r_op_b;
    assign bus.op_start    = w_op_start;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = w_out_valid;
    assign bus.busy        = w_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.op_count    = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_fp_op_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fp_op_sequencer : directed self-checking bench for fp_op_sequencer
// Rev 1.0
// ============================================================================
module tb_fp_op_sequencer;
    import fp_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fp_op_sequencer_if #(.DATA_W(16), .CNT_W(8)) bus ();

    fp_op_sequencer #(
        .DATA_W      (16),
        .TIMEOUT_CYC (32),
        .CNT_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.op_done   = 1'b0;
        bus.op_result = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Present one beat and hold until it is accepted.
    task automatic send_beat(input logic [15:0] d);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: in_ready=%b required 1 for data %h", bus.in_ready, d);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Op-unit model: op_done with res after lat more cycles.
    task automatic op_unit(input int lat, input logic [15:0] res);
        for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
        end
        bus.op_done   = 1'b1;
        bus.op_result = res;
        @(posedge clk); #1;
        bus.op_done   = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.op_a, bus.op_b, bus.out_data, bus.op_count} !== 56'h0 ||
            {bus.op_start, bus.out_valid, bus.busy, bus.timeout_err, bus.in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h out=%h cnt=%h start/valid/busy/err/rdy=%b%b%b%b%b required zeros and in_ready=1",
                     bus.op_a, bus.op_b, bus.out_data, bus.op_count, bus.op_start,
                     bus.out_valid, bus.busy, bus.timeout_err, bus.in_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_beat(16'h1234);
        send_beat(16'h5678);
        checks++;
        if (bus.op_start !== 1'b1 || bus.op_a !== 16'h1234 || bus.op_b !== 16'h5678) begin
            errors++;
            $display("FAIL basic_issue: start=%b a=%h b=%h required 1 1234 5678", bus.op_start, bus.op_a, bus.op_b);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.op_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: op_start=%b required 0 one cycle later", bus.op_start);
        end
        op_unit(2, 16'h68AC);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h68AC) begin
            errors++;
            $display("FAIL basic_result: valid=%b data=%h required 1 68ac", bus.out_valid, bus.out_data);
        end
        handshake();
        checks++;
        if (bus.op_count !== 8'd1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: cnt=%0d valid=%b busy=%b required 1 0 0", bus.op_count, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        send_beat(16'hABCD);
        send_beat(16'hEF01);
        bus.in_data  = 16'h9999;
        bus.in_valid = 1'b1;
        if (bus.in_ready !== 1'b0) bad++;
        op_unit(2, 16'h1357);
        for (int i = 0; i < 5; i++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h1357) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0 || bus.op_a !== 16'hABCD) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles, a=%h data=%h required 0 abcd 1357", bad, bus.op_a, bus.out_data);
        end
        handshake();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.op_a !== 16'hABCD || bus.op_count !== 8'd1) begin
            errors++;
            $display("FAIL bp_release: rdy=%b a=%h cnt=%0d required 1 abcd 1", bus.in_ready, bus.op_a, bus.op_count);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.op_a !== 16'h9999 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: a=%h busy=%b required 9999 1", bus.op_a, bus.busy);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        send_beat(16'h0A0A);
        send_beat(16'h0B0B);
        while (!bus.out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 32 || bus.out_data !== 16'h7E00 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout: cycles=%0d data=%h err=%b required 32 7e00 1", n, bus.out_data, bus.timeout_err);
        end
        handshake();
        send_beat(16'h0001);
        send_beat(16'h0002);
        op_unit(1, 16'h4242);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4242 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_next: valid=%b data=%h err=%b required 1 4242 1", bus.out_valid, bus.out_data, bus.timeout_err);
        end
        handshake();
        checks++;
        if (bus.op_count !== 8'd2) begin
            errors++;
            $display("FAIL timeout_count: cnt=%0d required 2", bus.op_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_beat(16'h0101);
        send_beat(16'h0202);
        op_unit(1, 16'h0303);
        handshake();
        send_beat(16'hAAAA);
        send_beat(16'hBBBB);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if ({bus.op_a, bus.op_b, bus.out_data, bus.op_count} !== 56'h0 ||
            {bus.op_start, bus.out_valid, bus.busy, bus.timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_clear: a=%h b=%h out=%h cnt=%0d start/valid/busy/err=%b%b%b%b required all 0",
                     bus.op_a, bus.op_b, bus.out_data, bus.op_count, bus.op_start,
                     bus.out_valid, bus.busy, bus.timeout_err);
        end
        bus.op_done   = 1'b1;
        bus.op_result = 16'hDEAD;
        @(posedge clk); #1;
        bus.op_done   = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
            errors++;
            $display("FAIL late_done: busy=%b valid=%b data=%h required 0 0 0000", bus.busy, bus.out_valid, bus.out_data);
        end
        send_beat(16'h1111);
        send_beat(16'h2222);
        op_unit(2, 16'h3333);
        checks++;
        if (bus.out_data !== 16'h3333) begin
            errors++;
            $display("FAIL midreset_op: data=%h required 3333", bus.out_data);
        end
        handshake();
        checks++;
        if (bus.op_count !== 8'd1) begin
            errors++;
            $display("FAIL midreset_count: cnt=%0d required 1", bus.op_count);
        end
    endtask

    task automatic test_equal_race();
        do_reset();
        send_beat(16'h3333);
        send_beat(16'h3333);
        checks++;
        if (bus.op_a !== 16'h3333 || bus.op_b !== 16'h3333) begin
            errors++;
            $display("FAIL equal_ops: a=%h b=%h required 3333 3333", bus.op_a, bus.op_b);
        end
        op_unit(31, 16'h6666);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h6666 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL race: valid=%b data=%h err=%b required 1 6666 0", bus.out_valid, bus.out_data, bus.timeout_err);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_beat(16'(i));
            send_beat(16'(i + 1));
            op_unit(1, 16'(i * 3));
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(i * 3)) bad++;
            @(posedge clk); #1;
            if (i == 254) begin
                checks++;
                if (bus.op_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255: cnt=%0d required 255", bus.op_count);
                end
            end
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.op_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap: cnt=%0d required 0", bus.op_count);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_data: %0d results wrong, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_equal_race();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_op_sequencer.md
FP_OP_SEQUENCER -- requirements
Module: fp_op_sequencer

Interface
REQ-001 Parameter DATA_W, default 16: operand/result word width (fp16).
REQ-002 Parameter TIMEOUT_CYC, default 32: max cycles in EXEC before the op is abandoned.
REQ-003 Parameter CNT_W, default 8: width of op_count.
REQ-004 The ports SHALL be:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  operand word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts a word.
- op_a  out  DATA_W  operand A to the fp op unit.
- op_b  out  DATA_W  operand B to the fp op unit.
- op_start  out  1  one-cycle start pulse to the op unit.
- op_done  in  1  op unit completion strobe.
- op_result  in  DATA_W  op unit result, valid with op_done.
- out_data  out  DATA_W  result word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state != WAIT_A.
- timeout_err  out  1  sticky op-unit timeout flag.
- op_count  out  CNT_W  completed result handshakes, modulo 2^CNT_W.

Function
REQ-005 FSM states SHALL be WAIT_A, WAIT_B, ISSUE, EXEC, RESP; the reset state is WAIT_A.
REQ-006 in_ready SHALL be 1 only in WAIT_A and WAIT_B; a beat is accepted when in_valid && in_ready at posedge.
REQ-007 WAIT_A: an accepted beat loads op_a and moves to WAIT_B; otherwise the FSM holds.
REQ-008 WAIT_B: an accepted beat loads op_b and moves to ISSUE; otherwise the FSM holds, with no limit on the gap between beats.
REQ-009 op_a/op_b SHALL hold their value from capture until the next capture; equal operands need no special handling.
REQ-010 ISSUE: op_start=1 for exactly one cycle, the timer clears, and the FSM moves to EXEC.
REQ-011 EXEC: on op_done, out_data <= op_result and the FSM moves to RESP; latency is ISSUE edge to out_valid = op-unit latency + 1 cycle.
REQ-012 EXEC with no op_done: the timer increments each cycle; when it reaches TIMEOUT_CYC-1, out_data <= 16'h7E00 (canonical NaN), timeout_err <= 1, and the FSM moves to RESP.
REQ-013 If op_done and the timeout occur in the same cycle, op_done SHALL win (result taken, no error).
REQ-014 op_done outside EXEC SHALL be ignored.
REQ-015 RESP: out_valid=1, and out_data SHALL stay stable until out_ready.
REQ-016 On the RESP handshake: op_count increments (wraps 2^CNT_W-1 -> 0), out_valid drops the next cycle, and the FSM returns to WAIT_A.
REQ-017 No new operand SHALL be accepted from ISSUE through the RESP handshake (single op in flight).
REQ-018 timeout_err SHALL stay set until reset and SHALL NOT block later ops.

Reset
REQ-019 When rst=0 at posedge, the block SHALL go to state WAIT_A and clear op_a, op_b, out_data, op_count, the timer and timeout_err to 0, and drive op_start and out_valid to 0.
REQ-020 Reset mid-operation (any state) SHALL abandon the op; a late op_done after reset SHALL be ignored.

Structure
REQ-021 Package fp_seq_pkg SHALL hold the state enum, FP16_QNAN = 16'h7E00, and the default DATA_W/TIMEOUT_CYC/CNT_W.
REQ-022 The timeout counter SHALL be a sub-module seq_timer (clear, enable, expired at TIMEOUT_CYC-1); the FSM and registers stay in fp_op_sequencer.

Verification
REQ-023 Reset, feed 16'h1234 then 16'h5678, model returns op_done with 16'h68AC after 3 cycles -> one op_start pulse with op_a=1234, op_b=5678; out_data=68AC; op_count=1.
REQ-024 Feed ABCD, EF01 with out_ready low for 5 cycles and in_valid held high with 9999 -> in_ready=0 throughout, out_data stable, 9999 accepted only after the handshake.
REQ-025 Feed operands, never assert op_done -> out_valid 32 cycles after op_start with out_data=7E00 and timeout_err=1; the next op completes normally with timeout_err still 1.
REQ-026 Assert rst=0 for 1 cycle in EXEC, then op_done arrives -> all outputs 0 and done ignored; then 1111/2222 completes with op_count=1.
REQ-027 Send 3333/3333 -> op_a=op_b=3333, and op_done coinciding with the timeout cycle returns the result with timeout_err=0.
REQ-028 Run 256 back-to-back ops -> op_count wraps to 0.
